player_damage_controller: RTL

Receiving end of the boss missile stream: converts collisions between boss missiles or the boss body and the player ship into life loss, invulnerability blinking, a dying window and a sticky death flag. Sits in the player block beside the ship bitmap. Its outputs gate the player's drawing request and colour and feed the game-state controller. All timing is in frames, advanced on startOfFrame while enable is high.

---
 rtl/player_damage_controller.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/player_damage_controller.sv
`default_nettype none
// ============================================================================
// Module      : player_damage_controller
// Description : Turns boss-missile / boss-body collisions with the player ship
//               into life loss, invulnerability blinking, a dying window and a
//               sticky death flag. All timing is counted in frames.
// Revision    : 1.0 - initial release
// ============================================================================
module player_damage_controller #(
    parameter int LIVES_AMOUNT_WIDTH = 4,
    parameter int LIVES_AMOUNT       = 3,
    parameter int MAX_LIVES          = 9,
    parameter int BODY_DAMAGE        = 2,
    parameter int INVULN_FRAMES      = 60,
    parameter int BLINK_FRAMES       = 4,
    parameter int DEATH_FRAMES       = 30
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          enable,
    input  logic                          startOfFrame,
    input  logic                          missile_collision,
    input  logic                          body_collision,
    input  logic                          extra_life,
    output logic [LIVES_AMOUNT_WIDTH-1:0] lives_left,
    output logic                          player_faded,
    output logic                          dying,
    output logic                          player_dead,
    output logic                          hit_pulse
);

    localparam int c_CNT_MAX = (INVULN_FRAMES > DEATH_FRAMES) ? INVULN_FRAMES : DEATH_FRAMES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int c_SUM_W   = LIVES_AMOUNT_WIDTH + 1;

    localparam logic [c_CNT_W-1:0]            c_INVULN_LOAD = c_CNT_W'(INVULN_FRAMES);
    localparam logic [c_CNT_W-1:0]            c_DEATH_LOAD  = c_CNT_W'(DEATH_FRAMES);
    localparam logic [c_CNT_W-1:0]            c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_BLINK_W-1:0]          c_BLINK_LAST  = c_BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [c_SUM_W-1:0]            c_MAX_WIDE    = c_SUM_W'(MAX_LIVES);
    localparam logic [c_SUM_W-1:0]            c_BODY_DMG    = c_SUM_W'(BODY_DAMAGE);
    localparam logic [LIVES_AMOUNT_WIDTH-1:0] c_LIVES_RST   = LIVES_AMOUNT_WIDTH'(LIVES_AMOUNT);
    localparam logic [LIVES_AMOUNT_WIDTH-1:0] c_LIVES_MAX   = LIVES_AMOUNT_WIDTH'(MAX_LIVES);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DYING  = 2'd2,
        ST_DEAD   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                          r_state;
    logic [LIVES_AMOUNT_WIDTH-1:0]   r_lives;
    logic [c_CNT_W-1:0]              r_cnt;
    logic [c_BLINK_W-1:0]            r_blink_cnt;
    logic                            r_faded_phase;
    logic                            r_hit;
    logic                            r_pend_m;
    logic                            r_pend_b;
    logic                            r_pend_x;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t                          w_state_next;
    logic [LIVES_AMOUNT_WIDTH-1:0]   w_lives_next;
    logic [c_CNT_W-1:0]              w_cnt_next;
    logic [c_BLINK_W-1:0]            w_blink_cnt_next;
    logic                            w_faded_phase_next;
    logic                            w_hit_next;
    logic                            w_pend_m_next;
    logic                            w_pend_b_next;
    logic                            w_pend_x_next;

    // ------------------------------------------------------------------------
    // Frame evaluation datapath
    // ------------------------------------------------------------------------
    logic                            w_eval;
    logic                            w_take_m;
    logic                            w_take_b;
    logic                            w_take_x;
    logic [c_SUM_W-1:0]              w_damage;
    logic [c_SUM_W-1:0]              w_sum;
    logic [c_SUM_W-1:0]              w_after_dmg;
    logic [LIVES_AMOUNT_WIDTH-1:0]   w_lives_hit;
    logic [LIVES_AMOUNT_WIDTH-1:0]   w_lives_heal;

    assign w_eval   = enable & startOfFrame;

    // The strobe cycle itself still belongs to the frame being closed.
    assign w_take_m = r_pend_m | missile_collision;
    assign w_take_b = r_pend_b | body_collision;
    assign w_take_x = r_pend_x | extra_life;

    always_comb begin
        w_damage = '0;
        if (w_take_b) begin
            w_damage = c_BODY_DMG;
        end else if (w_take_m) begin
            w_damage = c_SUM_W'(1);
        end
    end

    assign w_sum       = {1'b0, r_lives} + c_SUM_W'(w_take_x);
    assign w_after_dmg = (w_sum > w_damage) ? (w_sum - w_damage) : '0;

    assign w_lives_hit  = (w_after_dmg > c_MAX_WIDE) ? c_LIVES_MAX
                                                     : w_after_dmg[LIVES_AMOUNT_WIDTH-1:0];
    assign w_lives_heal = (w_sum > c_MAX_WIDE)       ? c_LIVES_MAX
                                                     : w_sum[LIVES_AMOUNT_WIDTH-1:0];

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_ALIVE;
            r_lives       <= c_LIVES_RST;
            r_cnt         <= '0;
            r_blink_cnt   <= '0;
            r_faded_phase <= 1'b0;
            r_hit         <= 1'b0;
            r_pend_m      <= 1'b0;
            r_pend_b      <= 1'b0;
            r_pend_x      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_lives       <= w_lives_next;
            r_cnt         <= w_cnt_next;
            r_blink_cnt   <= w_blink_cnt_next;
            r_faded_phase <= w_faded_phase_next;
            r_hit         <= w_hit_next;
            r_pend_m      <= w_pend_m_next;
            r_pend_b      <= w_pend_b_next;
            r_pend_x      <= w_pend_x_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_lives_next       = r_lives;
        w_cnt_next         = r_cnt;
        w_blink_cnt_next   = r_blink_cnt;
        w_faded_phase_next = r_faded_phase;
        w_hit_next         = 1'b0;
        w_pend_m_next      = r_pend_m;
        w_pend_b_next      = r_pend_b;
        w_pend_x_next      = r_pend_x;

        if (enable) begin
            w_pend_m_next = r_pend_m | missile_collision;
            w_pend_b_next = r_pend_b | body_collision;
            w_pend_x_next = r_pend_x | extra_life;
        end

        if (w_eval) begin
            w_pend_m_next = 1'b0;
            w_pend_b_next = 1'b0;
            w_pend_x_next = 1'b0;

            case (r_state)
                ST_ALIVE: begin
                    w_lives_next = w_lives_hit;
                    if (w_damage != '0) begin
                        w_hit_next = 1'b1;
                        if (w_lives_hit != '0) begin
                            w_state_next       = ST_INVULN;
                            w_cnt_next         = c_INVULN_LOAD;
                            w_blink_cnt_next   = '0;
                            w_faded_phase_next = 1'b1;
                        end else begin
                            w_state_next       = ST_DYING;
                            w_cnt_next         = c_DEATH_LOAD;
                            w_faded_phase_next = 1'b0;
                        end
                    end
                end

                ST_INVULN: begin
                    // Damage is swallowed here; only pickups still count.
                    w_lives_next = w_lives_heal;
                    if (r_blink_cnt == c_BLINK_LAST) begin
                        w_blink_cnt_next   = '0;
                        w_faded_phase_next = ~r_faded_phase;
                    end else begin
                        w_blink_cnt_next   = r_blink_cnt + c_BLINK_W'(1);
                    end
                    if (r_cnt <= c_CNT_ONE) begin
                        w_state_next       = ST_ALIVE;
                        w_cnt_next         = '0;
                        w_blink_cnt_next   = '0;
                        w_faded_phase_next = 1'b0;
                    end else begin
                        w_cnt_next         = r_cnt - c_CNT_ONE;
                    end
                end

                ST_DYING: begin
                    if (r_cnt <= c_CNT_ONE) begin
                        w_state_next = ST_DEAD;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next   = r_cnt - c_CNT_ONE;
                    end
                end

                ST_DEAD: begin
                    w_state_next = ST_DEAD;
                end

                default: begin
                    w_state_next = ST_ALIVE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign lives_left   = r_lives;
    assign player_faded = ((r_state == ST_INVULN) & r_faded_phase) | (r_state == ST_DEAD);
    assign dying        = (r_state == ST_DYING);
    assign player_dead  = (r_state == ST_DEAD);
    assign hit_pulse    = r_hit;

endmodule
`default_nettype wire
